// File: rtl/la_capture_pkg.sv
// Shared definitions for the logic-analyser capture block: FSM encoding and
// default channel width / FIFO depth.
package la_capture_pkg;

    localparam int CH_W_DEF       = 16;
    localparam int DEPTH_LOG2_DEF = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/la_capture_sync_fifo.sv
// First-word-fall-through synchronous FIFO. Pointers carry one extra MSB so
// full and empty are distinguishable; a write into a full FIFO is accepted
// only when a read happens in the same cycle.
module sync_fifo #(
    parameter int W          = 16,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [W-1:0]        mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_wr;
    logic                do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    assign do_rd = rd_en && !empty;
    // When full, the slot being written is the one being read out this cycle.
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end

    // Idle bus reads all ones so an empty FIFO never shows stale data.
    assign rd_data = empty ? '1 : mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/la_capture.sv
// Logic-analyser capture engine: synchronises the probe channels, samples
// them on a programmable divider tick, waits for a masked trigger pattern
// and streams samples into a FWFT FIFO for the USB writer.
module la_capture
    import la_capture_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int CH_W       = CH_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH_W-1:0] probe_in,
    input  logic [15:0]     div,
    input  logic [15:0]     cap_len,
    input  logic [CH_W-1:0] trig_mask,
    input  logic [CH_W-1:0] trig_value,
    input  logic            arm,
    input  logic            stop,
    output logic [CH_W-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            overflow,
    output state_t          state_dbg
);

    // Handshake: a word transfers on every clock where out_valid && out_ready;
    // out_valid/out_data hold steady until that transfer happens.

    logic [CH_W-1:0] sync1;
    logic [CH_W-1:0] sync2;
    logic [15:0]     div_cnt;
    logic [15:0]     cap_cnt;
    logic [15:0]     next_cnt;
    state_t          state;
    logic            tick;
    logic            arm_go;
    logic            trig_hit;
    logic            wr_req;
    logic            len_done;
    logic            fifo_empty;
    logic            fifo_full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= probe_in;
            sync2 <= sync1;
        end
    end

    assign tick   = (div_cnt == div);
    assign arm_go = (state == ST_IDLE) && arm && !stop;

    always_ff @(posedge clk) begin
        if (!rst || arm_go) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    assign trig_hit = (((sync2 ^ trig_value) & trig_mask) == '0);
    assign wr_req   = tick && !stop &&
                      (((state == ST_ARMED) && trig_hit) || (state == ST_CAPTURE));
    // The trigger sample is sample number one.
    assign next_cnt = (state == ST_ARMED) ? 16'd1 : cap_cnt + 16'd1;
    assign len_done = (cap_len != 16'd0) && (next_cnt == cap_len);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cap_cnt  <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state    <= ST_ARMED;
                        cap_cnt  <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_ARMED, ST_CAPTURE: begin
                    if (wr_req) begin
                        cap_cnt <= next_cnt;
                        // A dropped sample still counts toward the capture length.
                        if (fifo_full && !out_ready) overflow <= 1'b1;
                        if (len_done) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_CAPTURE;
                            busy  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;
    assign out_valid = !fifo_empty;

    sync_fifo #(
        .W          (CH_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_req),
        .wr_data (sync2),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: doc/la_capture.md
LA_CAPTURE -- requirements
Module: la_capture

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 9, FIFO depth exponent (512 words).
REQ-002 SHALL have parameter CH_W, default 16, channel count and data width.
REQ-003 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port probe_in, input, CH_W, raw asynchronous logic channels.
REQ-006 SHALL have port div, input, 16, sample every div+1 clocks.
REQ-007 SHALL have port cap_len, input, 16, samples to capture after trigger; 0 = unlimited.
REQ-008 SHALL have port trig_mask, input, CH_W, channels participating in the trigger.
REQ-009 SHALL have port trig_value, input, CH_W, required level on masked channels.
REQ-010 SHALL have port arm, input, 1, single-cycle start pulse.
REQ-011 SHALL have port stop, input, 1, single-cycle abort pulse.
REQ-012 SHALL have port out_data, output, CH_W, FIFO head word to the USB writer.
REQ-013 SHALL have port out_valid, output, 1, high when FIFO is non-empty.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts the word this cycle.
REQ-015 SHALL have port busy, output, 1, high in ARMED or CAPTURE.
REQ-016 SHALL have port overflow, output, 1, sticky; a sample was dropped on a full FIFO.

Function
REQ-017 SHALL pass probe_in through a two-flop synchronizer; the sampled value is the second-stage output.
REQ-018 SHALL run a 16-bit divider counter 0..div, asserting tick when count==div, then wrapping to 0.
- div=0 SHALL tick every cycle.
- The counter SHALL clear on arm.
REQ-019 SHALL implement states IDLE, ARMED and CAPTURE.
REQ-020 IDLE: arm SHALL move to ARMED, clear the captured-sample count and clear overflow.
REQ-021 ARMED: on tick with (sample & trig_mask)==(trig_value & trig_mask), the block SHALL write that sample and move to CAPTURE.
- trig_mask=0 SHALL trigger on the first tick.
REQ-022 CAPTURE: each tick SHALL write the sample and increment the 16-bit captured count.
- The trigger sample SHALL count as sample 1.
REQ-023 SHALL return to IDLE on the write that makes count==cap_len when cap_len!=0.
REQ-024 stop SHALL force IDLE from any state; a tick in that same cycle SHALL NOT write.
REQ-025 arm while busy SHALL be ignored.
REQ-026 SHALL accept a write when the FIFO is not full, or when it is full and a read occurs in the same cycle (occupancy unchanged).
REQ-027 A rejected write SHALL set overflow, still count toward cap_len, and leave FIFO contents intact.
REQ-028 SHALL present the FIFO as first-word-fall-through.
- out_data SHALL be valid whenever out_valid=1.
- A read SHALL occur when out_valid && out_ready.
- out_data/out_valid SHALL be stable until the read.
REQ-029 SHALL provide a write-to-out_valid latency of 1 clock into an empty FIFO.
REQ-030 SHALL allow reads in any state; IDLE SHALL NOT flush the FIFO.
REQ-031 SHALL wrap FIFO pointers modulo 2^DEPTH_LOG2 and use an extra MSB to distinguish full from empty.

Reset
REQ-032 While rst=0 at a clock edge, the block SHALL enter IDLE and empty the FIFO.
REQ-033 While rst=0 at a clock edge, outputs SHALL be: busy=0, overflow=0, out_valid=0, out_data=all ones.
REQ-034 While rst=0 at a clock edge, the synchronizer, divider and counters SHALL clear.
REQ-035 Reset mid-capture SHALL discard all buffered data.

Structure
REQ-036 A shared package SHALL hold the state encoding (IDLE=0, ARMED=1, CAPTURE=2) and the default CH_W and DEPTH_LOG2.
REQ-037 The FIFO SHALL be a sub-module sync_fifo (parameters W and DEPTH_LOG2) with ports wr_en, wr_data, rd_en, rd_data, empty, full.

Verification
REQ-038 Scenario 1: div=0, trig_mask=0, cap_len=4, probe ramps 0,1,2,..., arm, out_ready=1 -> four consecutive words out, then busy=0.
REQ-039 Scenario 2: trig_mask=16'h0001, trig_value=16'h0001, probe bit0 low for 10 cycles then high -> first output word has bit0=1; no earlier samples appear.
REQ-040 Scenario 3: div=3, trig_mask=0, cap_len=3 -> writes spaced exactly 4 clocks apart.
REQ-041 Scenario 4: out_ready=0, cap_len=0, div=0 -> after 512 words, overflow=1 and FIFO holds the first 512 samples in order.
REQ-042 Scenario 5: full FIFO with out_ready=1 and a tick in the same cycle -> write accepted, overflow stays 0.
REQ-043 Scenario 6: rst=0 pulse during CAPTURE with 5 words buffered -> next cycle out_valid=0, busy=0, out_data=16'hFFFF.
